// File: rtl/bytecode_fetch.sv
// Bytecode instruction fetch: reads opcode + 0..2 operand bytes and holds them for control.
// Optional branch support is enabled with `define BYTECODE_FETCH_BRANCH_EN.
module bytecode_fetch #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        op_code,
  output logic [7:0]        arg1,
  output logic [7:0]        arg2,
  output logic              op_valid,
  input  logic              op_done,
  input  logic              jump,
  input  logic [15:0]       offset,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    OP_ADDR, OP_DATA, A1_ADDR, A1_DATA, A2_ADDR, A2_DATA, ISSUE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fp;
  logic [ADDR_W-1:0] done_target;
  logic [7:0]        op_code_r;
  logic [7:0]        arg1_r;
  logic              two_ops;
  logic [1:0]        op_count;

  // NOTE: the default arm returns a value on every path, so no latch can be inferred.
  function automatic logic [1:0] operand_count(input logic [7:0] b);
    case (b)
      8'h10, 8'h12, 8'h15, 8'h36, 8'hBC: return 2'd1;
      8'h11, 8'h84:                      return 2'd2;
      default:                           return (b >= 8'h99 && b <= 8'hA8) ? 2'd2 : 2'd0;
    endcase
  endfunction

  assign op_count = operand_count(mem_data);
  assign mem_addr = fp;

`ifdef BYTECODE_FETCH_BRANCH_EN
  // Branch target is relative to the opcode address, wrapping modulo 2^ADDR_W.
  assign done_target = jump ? pc + ADDR_W'($signed(offset)) : fp;
`else
  logic unused_branch;
  assign done_target   = fp;
  assign unused_branch = &{1'b0, jump, offset};
`endif

  // NOTE: non-blocking assignments so every branch below reads pre-edge register values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OP_ADDR;
      fp        <= '0;
      mem_rd    <= 1'b0;
      op_code_r <= 8'h00;
      arg1_r    <= 8'h00;
      two_ops   <= 1'b0;
      op_code   <= 8'h00;
      arg1      <= 8'h00;
      arg2      <= 8'h00;
      op_valid  <= 1'b0;
      pc        <= '0;
    end else begin
      case (state)
        OP_ADDR: begin
          mem_rd <= 1'b1;
          state  <= OP_DATA;
        end
        OP_DATA: begin
          mem_rd    <= 1'b0;
          pc        <= fp;
          fp        <= fp + ADDR_W'(1);
          op_code_r <= mem_data;
          two_ops   <= (op_count == 2'd2);
          if (op_count == 2'd0) begin
            op_code  <= mem_data;
            op_valid <= 1'b1;
            state    <= ISSUE;
          end else begin
            state <= A1_ADDR;
          end
        end
        A1_ADDR: begin
          mem_rd <= 1'b1;
          state  <= A1_DATA;
        end
        A1_DATA: begin
          mem_rd <= 1'b0;
          fp     <= fp + ADDR_W'(1);
          if (two_ops) begin
            arg1_r <= mem_data;
            state  <= A2_ADDR;
          end else begin
            op_code  <= op_code_r;
            arg1     <= mem_data;
            op_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        A2_ADDR: begin
          mem_rd <= 1'b1;
          state  <= A2_DATA;
        end
        A2_DATA: begin
          mem_rd   <= 1'b0;
          fp       <= fp + ADDR_W'(1);
          op_code  <= op_code_r;
          arg1     <= arg1_r;
          arg2     <= mem_data;
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (op_done) begin
            op_valid <= 1'b0;
            op_code  <= 8'h00;
            arg1     <= 8'h00;
            arg2     <= 8'h00;
            fp       <= done_target;
            state    <= OP_ADDR;
          end
        end
        default: state <= OP_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Self-checking bench for bytecode_fetch: directed programs plus randomized instruction
// streams compared against an instruction-level reference model.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic [7:0]  op_code, arg1, arg2;
  logic        op_valid;
  logic        op_done;
  logic        jump;
  logic [15:0] offset;
  logic [15:0] pc;

  logic [7:0]  mem [0:65535];
  logic [15:0] fp_m;     // model: address of the next opcode to be presented
  logic [7:0]  exp_op;   // model: opcode currently expected on op_code
  int          checks = 0;
  int          errors = 0;

  bytecode_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .op_valid(op_valid),
    .op_done(op_done), .jump(jump), .offset(offset), .pc(pc)
  );

  always #5 clk = ~clk;

  // Program memory: byte returned in the cycle after the read strobe is registered.
  assign mem_data = mem_rd ? mem[mem_addr] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_ops(input logic [7:0] b);
    if (b inside {8'h10, 8'h12, 8'h15, 8'h36, 8'hBC}) return 1;
    if (b inside {8'h11, 8'h84, [8'h99:8'hA8]}) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] pick_op();
    case ($urandom_range(0, 3))
      0: return 8'($urandom);
      1: case ($urandom_range(0, 4))
           0: return 8'h10;
           1: return 8'h12;
           2: return 8'h15;
           3: return 8'h36;
           default: return 8'hBC;
         endcase
      2: return ($urandom_range(0, 1) == 1) ? 8'h84 : 8'(8'h99 + $urandom_range(0, 15));
      default: return 8'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; op_done = 1'b0; jump = 1'b0; offset = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_op_code", op_code, 0);
    check("rst_arg1", arg1, 0);
    check("rst_arg2", arg2, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_pc", pc, 0);
    rst  = 1'b0;
    fp_m = 16'h0;
  endtask

  // Wait for the next instruction (op_done noise while fetching must be ignored) and check it.
  task automatic expect_instr(input bit from_reset);
    logic [15:0] a;
    logic [7:0]  e1, e2;
    int n, k, rd_k, exp_lat;
    exp_op = mem[fp_m];
    n  = n_ops(exp_op);
    a  = fp_m + 16'd1;
    e1 = (n >= 1) ? mem[a] : 8'h00;
    a  = fp_m + 16'd2;
    e2 = (n == 2) ? mem[a] : 8'h00;
    exp_lat = 2 * (1 + n) + (from_reset ? 0 : 1);
    k    = from_reset ? 0 : 1;
    rd_k = from_reset ? 1 : 2;
    while (!op_valid && k < 40) begin
      if (k == rd_k) begin
        check("fetch_rd", mem_rd, 1);
        check("fetch_addr", mem_addr, fp_m);
      end
      op_done = 1'($urandom_range(0, 1));
      jump    = 1'($urandom_range(0, 1));
      offset  = 16'($urandom);
      @(negedge clk);
      k++;
    end
    op_done = 1'b0; jump = 1'b0; offset = 16'h0;
    check("valid_timeout", op_valid, 1);
    check("latency", k, exp_lat);
    check("op_code", op_code, exp_op);
    check("arg1", arg1, e1);
    check("arg2", arg2, e2);
    check("pc", pc, fp_m);
  endtask

  task automatic hold(input int c);
    repeat (c) @(negedge clk);
    check("hold_valid", op_valid, 1);
    check("hold_op", op_code, exp_op);
  endtask

  task automatic issue_done(input logic j, input logic [15:0] off);
    logic [15:0] nxt;
    nxt = fp_m + 16'(1 + n_ops(mem[fp_m]));
`ifdef BYTECODE_FETCH_BRANCH_EN
    if (j) nxt = fp_m + off;
`endif
    fp_m = nxt;
    op_done = 1'b1; jump = j; offset = off;
    @(negedge clk);
    op_done = 1'b0; jump = 1'b0; offset = 16'h0;
    check("done_valid", op_valid, 0);
    check("done_op", op_code, 0);
    check("done_arg1", arg1, 0);
    check("done_arg2", arg2, 0);
    check("done_addr", mem_addr, fp_m);
  endtask

  initial begin
    rst = 1'b1; op_done = 1'b0; jump = 1'b0; offset = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Three 0-operand opcodes back to back.
    mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h60;
    do_reset();
    expect_instr(1'b1);
    check("tp1_op", op_code, 8'h02);
    issue_done(1'b0, 16'h0); expect_instr(1'b0);
    issue_done(1'b0, 16'h0); expect_instr(1'b0);
    check("tp1_pc3", pc, 16'd2);

    // bipush then sipush.
    mem[0] = 8'h10; mem[1] = 8'h7F; mem[2] = 8'h11; mem[3] = 8'h12; mem[4] = 8'h34;
    do_reset();
    expect_instr(1'b1);
    issue_done(1'b0, 16'h0); expect_instr(1'b0);
    check("sipush_arg1", arg1, 8'h12);
    check("sipush_arg2", arg2, 8'h34);

    // Sixteen nops then goto at 0x0010 with offset -16.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[16] = 8'hA7; mem[17] = 8'hFF; mem[18] = 8'hF0;
    do_reset();
    expect_instr(1'b1);
    repeat (16) begin
      issue_done(1'b0, 16'h0); expect_instr(1'b0);
    end
    check("goto_pc", pc, 16'h0010);
    issue_done(1'b1, 16'hFFF0);
`ifdef BYTECODE_FETCH_BRANCH_EN
    check("goto_target", mem_addr, 16'h0000);
`else
    check("goto_target", mem_addr, 16'h0013);
`endif
    expect_instr(1'b0);

`ifdef BYTECODE_FETCH_BRANCH_EN
    // Branch wrap from 0xFFFE, then sequential wrap through 0xFFFF.
    mem[16'hFFFE] = 8'h00;
    issue_done(1'b1, 16'hFFFE - fp_m); expect_instr(1'b0);
    issue_done(1'b1, 16'h0004);
    check("wrap_target", mem_addr, 16'h0002);
    expect_instr(1'b0);
    mem[16'hFFFE] = 8'h10;
    issue_done(1'b1, 16'hFFFC); expect_instr(1'b0);
    issue_done(1'b0, 16'h0);
    check("seq_wrap", mem_addr, 16'h0000);
    expect_instr(1'b0);
`endif

    // Randomized instruction stream with random hold times and branch requests.
    repeat (300) begin
      hold($urandom_range(0, 2));
      issue_done(1'($urandom_range(0, 1)), 16'($urandom));
      mem[fp_m] = pick_op();
      expect_instr(1'b0);
    end

    // Asynchronous reset while an instruction is presented.
    #2 rst = 1'b1;
    #1;
    check("arst_valid", op_valid, 0);
    check("arst_op", op_code, 0);
    check("arst_arg1", arg1, 0);
    check("arst_arg2", arg2, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_rd", mem_rd, 0);
    check("arst_pc", pc, 0);
    @(negedge clk);
    rst  = 1'b0;
    fp_m = 16'h0;
    expect_instr(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
